tex_qspi_arbiter: RTL

- Shares the external QSPI texture flash between two texture-fetch requesters inside rbzero (e.g. wall column and floor/ceiling fetch).
- Runs complete Quad-Output Fast Read (0x6B) transactions that return one byte each.
- Drives the o_tex_* pad signals that the top wrapper routes to the IO pads.
- Arbitrates round-robin between the two requesters and enforces CSB high time between transactions.

---
 rtl/tex_qspi_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/tex_qspi_arbiter.sv
// Two-requester arbiter for the QSPI texture flash. Each grant runs a complete
// Quad-Output Fast Read (0x6B) returning one byte; requesters alternate on ties.
// Optional last-hit cache is enabled by defining TEX_LAST_HIT_EN.
module tex_qspi_arbiter #(
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter int unsigned CSB_GAP      = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req0,
  input  logic [23:0] i_addr0,
  output logic        o_ack0,
  input  logic        i_req1,
  input  logic [23:0] i_addr1,
  output logic        o_ack1,
  output logic [7:0]  o_data,
  output logic        o_busy,
  output logic        o_tex_csb,
  output logic        o_tex_sclk,
  output logic        o_tex_oeb0,
  output logic        o_tex_out0,
  input  logic [3:0]  i_tex_in
);

  localparam logic [7:0] CmdFastReadQuad = 8'h6B;
  localparam logic [4:0] DummyLast       = 5'(DUMMY_CYCLES - 1);
  localparam logic [3:0] GapLoad         = 4'(CSB_GAP - 1);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StGap} state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;   // 0: sclk low, 1: sclk high
  logic [4:0]  cnt_q, cnt_d;       // SPI period index within the current state
  logic [3:0]  gap_q, gap_d;       // remaining gap cycles; 0 means expired
  logic        gid_q, gid_d;       // granted requester
  logic        rr_q, rr_d;         // requester that wins the next tie
  logic [23:0] addr_q, addr_d;
  logic [3:0]  rx_q, rx_d;         // upper nibble captured in the first data period
  logic [7:0]  data_q, data_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        grant_ok, sel;
  logic [23:0] gaddr;
`ifdef TEX_LAST_HIT_EN
  logic [23:0] last_addr_q, last_addr_d;
  logic [7:0]  last_data_q, last_data_d;
  logic        last_vld_q, last_vld_d;
`endif

  // Next-state: SPI sequencing, gap timing and round-robin grant.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    gid_d    = gid_q;
    rr_d     = rr_q;
    addr_d   = addr_q;
    rx_d     = rx_q;
    data_d   = data_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    grant_ok = 1'b0;
    sel      = 1'b0;
    gaddr    = i_addr0;
`ifdef TEX_LAST_HIT_EN
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    last_vld_d  = last_vld_q;
`endif
    unique case (state_q)
      StIdle: grant_ok = 1'b1;
      StGap: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else begin
          // Last gap cycle doubles as the idle decision so CSB high time is exactly CSB_GAP.
          grant_ok = 1'b1;
          state_d  = StIdle;
        end
      end
      StCmd, StAddr, StDummy, StData: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 5'd1;
          if (state_q == StCmd && cnt_q == 5'd7) begin
            state_d = StAddr;
            cnt_d   = '0;
          end else if (state_q == StAddr && cnt_q == 5'd23) begin
            state_d = StDummy;
            cnt_d   = '0;
          end else if (state_q == StDummy && cnt_q == DummyLast) begin
            state_d = StData;
            cnt_d   = '0;
          end else if (state_q == StData) begin
            if (cnt_q == 5'd0) begin
              rx_d = i_tex_in;
            end else begin
              data_d  = {rx_q, i_tex_in};
              // A dropped request still completes, but gets no ack.
              ack0_d  = ~gid_q & i_req0;
              ack1_d  = gid_q & i_req1;
              state_d = StGap;
              phase_d = 1'b0;
              gap_d   = GapLoad;
`ifdef TEX_LAST_HIT_EN
              last_addr_d = addr_q;
              last_data_d = {rx_q, i_tex_in};
              last_vld_d  = 1'b1;
`endif
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant_ok && (i_req0 || i_req1)) begin
      if (i_req0 && i_req1) begin
        sel  = rr_q;
        rr_d = ~rr_q;
      end else begin
        sel = i_req1;
      end
      gaddr  = sel ? i_addr1 : i_addr0;
      gid_d  = sel;
      addr_d = gaddr;
`ifdef TEX_LAST_HIT_EN
      if (last_vld_q && gaddr == last_addr_q) begin
        ack0_d  = ~sel;
        ack1_d  = sel;
        data_d  = last_data_q;
        state_d = StIdle;
      end else begin
        state_d = StCmd;
        phase_d = 1'b0;
        cnt_d   = '0;
      end
`else
      state_d = StCmd;
      phase_d = 1'b0;
      cnt_d   = '0;
`endif
    end
  end

  // State registers; reset leaves the gap expired and requester 0 first on a tie.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
      gid_q   <= 1'b0;
      rr_q    <= 1'b0;
      addr_q  <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
`ifdef TEX_LAST_HIT_EN
      last_addr_q <= '0;
      last_data_q <= '0;
      last_vld_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
`ifdef TEX_LAST_HIT_EN
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      last_vld_q  <= last_vld_d;
`endif
    end
  end

  // Pad and status outputs decoded from registered state only.
  always_comb begin
    o_ack0     = ack0_q;
    o_ack1     = ack1_q;
    o_data     = data_q;
    o_busy     = (state_q != StIdle);
    o_tex_csb  = 1'b1;
    o_tex_sclk = 1'b0;
    o_tex_oeb0 = 1'b0;
    o_tex_out0 = 1'b0;
    if (state_q inside {StCmd, StAddr, StDummy, StData}) begin
      o_tex_csb  = 1'b0;
      o_tex_sclk = phase_q;
    end
    if (state_q == StCmd) o_tex_out0 = CmdFastReadQuad[3'(3'd7 - cnt_q[2:0])];
    if (state_q == StAddr) o_tex_out0 = addr_q[5'd23 - cnt_q];
    if (state_q inside {StDummy, StData}) o_tex_oeb0 = 1'b1;
  end

endmodule
